// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction ROM
// and registers the fetched word, its PC and a misaligned-fetch flag into IF/ID.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_adel_o
);

  logic        ce_reg;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic [31:0] id_inst_reg, id_inst_next;
  logic        id_adel_reg, id_adel_next;
  logic        misaligned;

  assign misaligned = (pc_reg[1:0] != 2'b00);

  // Flush outranks the PC stall; a branch seen during a PC stall is dropped
  // because ID re-presents it once the stall releases.
  always_comb begin
    pc_next = pc_reg;
    if (!ce_reg) begin
      pc_next = RESET_PC;
    end else if (flush_i) begin
      pc_next = new_pc_i;
    end else if (stall_i[0]) begin
      pc_next = pc_reg;
    end else if (branch_flag_i) begin
      pc_next = branch_target_i;
    end else begin
      pc_next = pc_reg + 32'd4;
    end
  end

  always_comb begin
    id_pc_next   = id_pc_reg;
    id_inst_next = id_inst_reg;
    id_adel_next = id_adel_reg;
    if (flush_i || (stall_i[1] && !stall_i[2]) || (!stall_i[1] && !ce_reg)) begin
      id_pc_next   = 32'd0;
      id_inst_next = NOP_INST;
      id_adel_next = 1'b0;
    end else if (!stall_i[1]) begin
      // A misaligned fetch never forwards ROM data; the flag is the only trace.
      id_pc_next   = pc_reg;
      id_inst_next = misaligned ? NOP_INST : rom_data_i;
      id_adel_next = misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce_reg      <= 1'b0;
      pc_reg      <= RESET_PC;
      id_pc_reg   <= 32'd0;
      id_inst_reg <= NOP_INST;
      id_adel_reg <= 1'b0;
    end else begin
      ce_reg      <= 1'b1;
      pc_reg      <= pc_next;
      id_pc_reg   <= id_pc_next;
      id_inst_reg <= id_inst_next;
      id_adel_reg <= id_adel_next;
    end
  end

  assign rom_ce_o   = ce_reg;
  assign rom_addr_o = pc_reg;
  assign id_pc_o    = id_pc_reg;
  assign id_inst_o  = id_inst_reg;
  assign id_adel_o  = id_adel_reg;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the OpenMIPS core. It owns the program counter, drives the instruction ROM's chip-enable and address, and registers the returned word into the IF/ID pipeline register for the decode stage. It handles pipeline stall, branch redirect (MIPS delay-slot semantics), exception flush and misaligned-fetch detection. The ROM is combinational: the instruction is valid in the same cycle as `rom_addr_o`.

## Interface

Parameters:

- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, default 32'h0000_0000: word inserted as a bubble.

Ports:

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall_i` input 3: stall vector. Bit 0 holds the PC, bit 1 holds IF, bit 2 holds ID.
- `branch_flag_i` input 1: branch taken, from ID.
- `branch_target_i` input 32: branch target address.
- `flush_i` input 1: exception flush.
- `new_pc_i` input 32: exception handler address, used with `flush_i`.
- `rom_ce_o` output 1: ROM chip enable.
- `rom_addr_o` output 32: current PC, drives the ROM address.
- `rom_data_i` input 32: instruction from the ROM, combinational.
- `id_pc_o` output 32: registered PC of the instruction sent to ID.
- `id_inst_o` output 32: registered instruction sent to ID.
- `id_adel_o` output 1: registered misaligned-fetch flag for that instruction.

## Operation

- **Reset.** While `rst` is 1, every register is loaded at the clock edge:
  - `rom_ce_o`=0
  - PC=`RESET_PC`
  - `id_pc_o`=0
  - `id_inst_o`=`NOP_INST`
  - `id_adel_o`=0
- **Enable.** With `rst`=0, `rom_ce_o` becomes 1 at the next edge and stays 1.
- **PC update.** While `rom_ce_o`=0 the PC holds `RESET_PC`. While `rom_ce_o`=1, the next PC is chosen by this priority, highest first:
  1. `flush_i`=1 → `new_pc_i`. This applies regardless of `stall_i`.
  2. `stall_i[0]`=1 → PC holds.
  3. `branch_flag_i`=1 → `branch_target_i`.
  4. Otherwise → PC+4. The add is 32-bit modulo: 32'hFFFF_FFFC wraps to 0.
- **Branch while stalled.** A branch with `stall_i[0]`=1 is ignored. ID holds its branch and reasserts `branch_flag_i` when the stall releases.
- **Delay slot.** The instruction being fetched in the cycle `branch_flag_i` is sampled is the delay slot. It enters IF/ID normally and is never squashed by a branch.
- **IF/ID register update.** Priority, highest first:
  1. `rst` or `flush_i` → bubble: pc=0, inst=`NOP_INST`, adel=0.
  2. `stall_i[1]`=1 and `stall_i[2]`=0 → bubble.
  3. `stall_i[1]`=1 and `stall_i[2]`=1 → hold all three outputs.
  4. `stall_i[1]`=0 → capture `rom_addr_o` into pc, plus the instruction and the flag defined by the misaligned-fetch rule.
- **Misaligned fetch.** If `rom_addr_o[1:0]` != 0 on a capture, `id_inst_o` gets `NOP_INST` (the ROM data is discarded) and `id_adel_o` gets 1. The PC itself is not realigned; flush is the only recovery.
- **Disabled ROM.** A capture taken while `rom_ce_o`=0 loads a bubble.

## Timing

- **Latency.** The PC presented in cycle N appears on `id_pc_o`/`id_inst_o` after the edge ending cycle N: 1 cycle.
- **Reset release.**
  - First edge with `rst`=0: `rom_ce_o`=1, PC=`RESET_PC`.
  - Next edge: the `RESET_PC` instruction is in IF/ID, and PC=`RESET_PC`+4.
- **Branch.** Sampled at edge E. PC=target after E. The delay slot is in IF/ID after E. The target instruction is in IF/ID after E+1.
- **Flush.** Sampled at edge E. PC=`new_pc_i` and IF/ID holds a bubble after E. The handler's first instruction is in IF/ID after E+1.
- **Flush and branch together.** Flush wins.
- **Flush and stall together.** Flush wins for both the PC and IF/ID.
- **Reset mid-stream.** Reset overrides everything at that edge. The sequence restarts as for reset release.

## Test plan

1. **Reset release.** Hold `rst` 3 cycles, then release. ROM word = address. Expected:
   - `rom_ce_o` goes 0 → 1.
   - `rom_addr_o` sequence: 0, 0, 4, 8.
   - `id_inst_o` sequence: NOP, NOP, 0, 4, 8.
2. **Branch with delay slot.** At PC=0x10 assert `branch_flag_i` with target 0x40 for one cycle. Expected:
   - `rom_addr_o` sequence: 0x10, 0x40, 0x44.
   - `id_pc_o` sequence: 0x0C, 0x10, 0x40.
3. **Stall.** At PC=0x20:
   - Assert `stall_i`=3'b011 for 2 cycles. Expected: PC holds 0x20, and `id_inst_o`=NOP for 2 cycles.
   - Then apply `stall_i`=3'b111. Expected: IF/ID holds its value.
   - Release. Expected: the fetch sequence resumes at 0x20 then 0x24, with no instruction lost or duplicated.
4. **Flush over stall and branch.** Assert `flush_i` with `new_pc_i`=0x180 together with `branch_flag_i` (target 0x40) and `stall_i`=3'b111. Expected:
   - PC=0x180 next cycle.
   - IF/ID is a bubble next cycle.
   - `id_pc_o`=0x180 the following cycle.
5. **Misaligned branch.** Branch to 0x42. Expected:
   - `id_pc_o`=0x42, `id_adel_o`=1, `id_inst_o`=NOP.
   - A subsequent flush to 0x180 clears `id_adel_o` to 0.
6. **Wrap and mid-run reset.**
   - Flush to 0xFFFF_FFFC. Expected: next `rom_addr_o`=0.
   - Assert `rst` mid-run. Expected: all outputs return to their reset values at the next edge.
